// File: rtl/volume_pkg.sv
// Shared volume types and default sizing for the button, ramp and display blocks.
package volume_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    localparam int VOL_WIDTH     = 4;
    localparam int VOL_MAX_LEVEL = 15;

endpackage

// File: rtl/volume_pwm.sv
// PWM generator: period MAX_LEVEL cycles, duty level/MAX_LEVEL, registered output.
module volume_pwm #(
    parameter int WIDTH     = 4,
    parameter int MAX_LEVEL = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic             pwm
);

    localparam int PW = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

    logic [PW-1:0] pwm_cnt;

    // Free-running period counter 0..MAX_LEVEL-1 and registered duty compare
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt <= '0;
            pwm     <= 1'b0;
        end else begin
            pwm_cnt <= (32'(pwm_cnt) == MAX_LEVEL - 1) ? '0 : pwm_cnt + PW'(1);
            pwm     <= (32'(pwm_cnt) < 32'(level));
        end
    end

endmodule

// File: rtl/volume_ctrl.sv
// Volume controller: saturating target, soft-ramped level, PWM output and status flags.
module volume_ctrl
    import volume_pkg::*;
#(
    parameter int WIDTH      = VOL_WIDTH,
    parameter int MAX_LEVEL  = VOL_MAX_LEVEL,
    parameter int INIT_LEVEL = 8,
    parameter int RAMP_DIV   = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             increment,
    input  logic             decrement,
    input  logic             mute,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] level,
    output logic             pwm,
    output logic             busy,
    output logic             at_max,
    output logic             at_min
);

    localparam int                CW     = $clog2(RAMP_DIV);
    localparam logic [WIDTH-1:0]  MAX_L  = WIDTH'(MAX_LEVEL);
    localparam logic [WIDTH-1:0]  INIT_L = WIDTH'(INIT_LEVEL);
    localparam logic [CW-1:0]     CNT_TC = CW'(RAMP_DIV - 1);

    ramp_state_t      state, state_nxt;
    logic [CW-1:0]    ramp_cnt, cnt_nxt;
    logic [WIDTH-1:0] level_nxt;
    logic [WIDTH-1:0] eff;

    // Saturating user target; simultaneous inc/dec cancel out
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            target <= INIT_L;
        else if (increment && !decrement && target < MAX_L)
            target <= target + WIDTH'(1);
        else if (decrement && !increment && target != '0)
            target <= target - WIDTH'(1);
    end

    assign eff = mute ? '0 : target;

    // Ramp state, level and divider registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            level    <= INIT_L;
            ramp_cnt <= '0;
        end else begin
            state    <= state_nxt;
            level    <= level_nxt;
            ramp_cnt <= cnt_nxt;
        end
    end

    // Next ramp state: direction reversal or arrival wins over the divider
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (eff > level)      state_nxt = RAMP_UP;
                else if (eff < level) state_nxt = RAMP_DOWN;
            end
            RAMP_UP: begin
                if (eff == level)         state_nxt = IDLE;
                else if (eff < level)     state_nxt = RAMP_DOWN;
                else if (ramp_cnt == CNT_TC && level + WIDTH'(1) == eff)
                                          state_nxt = IDLE;
            end
            RAMP_DOWN: begin
                if (eff == level)         state_nxt = IDLE;
                else if (eff > level)     state_nxt = RAMP_UP;
                else if (ramp_cnt == CNT_TC && level - WIDTH'(1) == eff)
                                          state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Level stepping and divider; any exit from a ramp restarts the divider
    always_comb begin
        level_nxt = level;
        cnt_nxt   = '0;
        case (state)
            RAMP_UP: begin
                if (eff > level) begin
                    if (ramp_cnt == CNT_TC) level_nxt = level + WIDTH'(1);
                    else                    cnt_nxt   = ramp_cnt + CW'(1);
                end
            end
            RAMP_DOWN: begin
                if (eff < level) begin
                    if (ramp_cnt == CNT_TC) level_nxt = level - WIDTH'(1);
                    else                    cnt_nxt   = ramp_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // Status flags
    always_comb begin
        busy   = (state != IDLE);
        at_max = (target == MAX_L);
        at_min = (target == '0);
    end

    volume_pwm #(
        .WIDTH     (WIDTH),
        .MAX_LEVEL (MAX_LEVEL)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .level (level),
        .pwm   (pwm)
    );

endmodule

// File: tb/tb_volume_ctrl.sv
// Bench for volume_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_volume_ctrl;

    localparam int WIDTH = 4, MAXL = 15, INIT = 8, DIV = 4;

    logic             clk = 0, reset = 1;
    logic             increment = 0, decrement = 0, mute = 0;
    logic [WIDTH-1:0] target, level;
    logic             pwm, busy, at_max, at_min;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    // model state: volumes as plain integers, ramp as direction + age
    int m_target, m_level, m_dir, m_age, m_t;
    bit m_pwm;

    volume_ctrl #(.WIDTH(WIDTH), .MAX_LEVEL(MAXL), .INIT_LEVEL(INIT), .RAMP_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .increment(increment), .decrement(decrement), .mute(mute),
        .target(target), .level(level), .pwm(pwm), .busy(busy), .at_max(at_max), .at_min(at_min)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: ramp direction follows sign(eff-level); one step after DIV
    // cycles of continuous ramping in the same direction, restarted on any change.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_target = INIT; m_level = INIT; m_dir = 0; m_age = 0; m_t = 0; m_pwm = 0;
            end else begin
                int eff, d;
                eff = mute ? 0 : m_target;
                d   = (eff > m_level) ? 1 : (eff < m_level) ? -1 : 0;
                m_pwm = ((m_t % MAXL) < m_level);
                m_t++;
                if (m_dir == 0 || d != m_dir) begin
                    m_dir = d; m_age = 0;
                end else begin
                    m_age++;
                    if (m_age == DIV) begin
                        m_level += d; m_age = 0;
                        if (m_level == eff) m_dir = 0;
                    end
                end
                if (increment && !decrement && m_target < MAXL) m_target++;
                else if (decrement && !increment && m_target > 0) m_target--;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                chk("target", target, m_target);
                chk("level", level, m_level);
                chk("busy", busy, int'(m_dir != 0));
                chk("at_max", at_max, int'(m_target == MAXL));
                chk("at_min", at_min, int'(m_target == 0));
                chk("pwm", pwm, m_pwm);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit inc, input bit dec, input int n);
        increment = inc; decrement = dec;
        tick(n);
        increment = 0; decrement = 0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin tick(1); n++; end
        chk("wait_idle_timeout", busy, 0);
    endtask

    task automatic count_pwm(input int n, output int highs);
        highs = 0;
        repeat (n) begin tick(1); highs += pwm; end
    endtask

    initial begin
        int h, n, lmax, lmin;
        tick(3);
        reset = 0;
        chk_en = 1;
        tick(1);
        count_pwm(15, h);
        chk("duty_init", h, 8);

        // async reset in the middle of a ramp
        pulse(1, 0, 1);
        tick(3);
        @(posedge clk); #3;
        reset = 1; #1;
        chk("rst_target", target, 8);
        chk("rst_level", level, 8);
        chk("rst_busy", busy, 0);
        chk("rst_pwm", pwm, 0);
        tick(2);
        reset = 0;
        tick(2);

        // single increment latency
        pulse(1, 0, 1);
        chk("inc_target", target, 9);
        chk("inc_busy_k", busy, 0);
        tick(1);
        chk("inc_busy_k1", busy, 1);
        tick(3);
        chk("inc_level_k4", level, 8);
        tick(1);
        chk("inc_level_k5", level, 9);
        chk("inc_idle_k5", busy, 0);

        // saturation and simultaneous inputs
        pulse(1, 0, 10);
        chk("sat_max", target, 15);
        chk("sat_at_max", at_max, 1);
        pulse(1, 1, 3);
        chk("both_hold", target, 15);
        pulse(0, 1, 20);
        chk("sat_min", target, 0);
        chk("sat_at_min", at_min, 1);
        wait_idle(100);

        // pwm extremes
        chk("lvl0", level, 0);
        count_pwm(30, h);
        chk("pwm_lvl0", h, 0);
        pulse(1, 0, 15);
        wait_idle(100);
        tick(1);
        count_pwm(30, h);
        chk("pwm_lvl15", h, 30);
        pulse(0, 1, 10);
        wait_idle(100);
        tick(1);
        count_pwm(15, h);
        chk("pwm_lvl5", h, 5);

        // mute mid-ramp, unmute at level 3
        pulse(1, 0, 3);
        wait_idle(100);
        chk("mute_start", level, 8);
        mute = 1;
        n = 0; lmax = 0;
        while (level !== 3 && n < 100) begin tick(1); n++; end
        chk("mute_reach3", level, 3);
        chk("mute_target", target, 8);
        mute = 0;
        n = 0;
        while (level !== 8 && n < 100) begin
            tick(1); n++;
            if (level > lmax) lmax = level;
        end
        tick(DIV + 2);
        if (level > lmax) lmax = level;
        chk("unmute_level", level, 8);
        chk("unmute_overshoot", lmax, 8);
        chk("unmute_idle", busy, 0);

        // reversal before the first step
        lmax = 8; lmin = 8;
        pulse(1, 0, 2);
        tick(1);
        pulse(0, 1, 2);
        n = 0;
        while (n < 10) begin
            tick(1); n++;
            if (level > lmax) lmax = level;
            if (level < lmin) lmin = level;
        end
        chk("rev_target", target, 8);
        chk("rev_idle", busy, 0);
        chk("rev_lmax", lmax, 8);
        chk("rev_lmin", lmin, 8);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            increment = (r < 20) || (r >= 95);
            decrement = (r >= 20 && r < 40) || (r >= 95);
            if ($urandom_range(0, 49) == 0) mute = ~mute;
            tick(1);
        end
        increment = 0; decrement = 0; mute = 0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
